// File: rtl/cpu_exc_pkg.sv
// Shared exception-controller definitions: exception codes, m_exc flag positions,
// CP0 write-strobe positions, controller FSM states and the default exception vector.
package cpu_exc_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // m_exc bit positions; ascending index is also descending priority
    localparam int EXC_BIT_ADEL_IF = 0;
    localparam int EXC_BIT_RI      = 1;
    localparam int EXC_BIT_OV      = 2;
    localparam int EXC_BIT_SYS     = 3;
    localparam int EXC_BIT_BP      = 4;
    localparam int EXC_BIT_ADEL_D  = 5;
    localparam int EXC_BIT_ADES    = 6;

    localparam int CP0_WE_BADVADDR = 8;
    localparam int CP0_WE_STATUS   = 12;
    localparam int CP0_WE_CAUSE    = 13;
    localparam int CP0_WE_EPC      = 14;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer for the external interrupt lines.
module int_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: picks the commit-stage event, updates CP0 and redirects fetch.
// Optional compare/count timer interrupt on line 5 is built when EXC_TIMER_INT_EN is defined.
module exc_ctrl
    import cpu_exc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_valid,
    input  logic [WIDTH-1:0] m_pc,
    input  logic             m_bd,
    input  logic             m_eret,
    input  logic [6:0]       m_exc,
    input  logic [WIDTH-1:0] m_badvaddr,
    input  logic [5:0]       hw_int,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] cause_in,
    input  logic [WIDTH-1:0] epc_in,
    input  logic             cmp_we,
    input  logic [WIDTH-1:0] cmp_wdata,
    output logic [WIDTH-1:0] cp0_we,
    output logic [WIDTH-1:0] cp0_epc,
    output logic [WIDTH-1:0] cp0_badaddr,
    output logic [4:0]       cp0_exccode,
    output logic             cp0_exl,
    output logic             cp0_bd,
    output logic [5:0]       cp0_hw_int,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    input  logic             redirect_ready,
    output logic             busy
);

    exc_state_e       state_q, state_d;
    logic [5:0]       sync_int;
    logic             int_pending;
    logic             take, take_eret, take_addr, bad_from_pc, bad_from_data;
    logic [4:0]       take_code;
    logic [WIDTH-1:0] epc_q, badaddr_q, redir_pc_q;
    logic [4:0]       exccode_q;
    logic             bd_q, eret_q, addr_fault_q;
    logic             unused_ok;

    int_sync #(.W(6)) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (hw_int),
        .sync_o  (sync_int)
    );

`ifdef EXC_TIMER_INT_EN
    logic [31:0] count_q, compare_q;
    logic        timer_pend_q;

    // A compare write always wins over a match in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            compare_q    <= '0;
            timer_pend_q <= 1'b0;
        end else begin
            count_q <= count_q + 32'd1;
            if (cmp_we) begin
                compare_q    <= cmp_wdata[31:0];
                timer_pend_q <= 1'b0;
            end else if (count_q == compare_q) begin
                timer_pend_q <= 1'b1;
            end
        end
    end

    assign cp0_hw_int = {timer_pend_q, sync_int[4:0]};
    assign unused_ok  = ^{status_in[WIDTH-1:16], status_in[7:2], cause_in[WIDTH-1:16],
                          cause_in[7:0], sync_int[5]};
`else
    assign cp0_hw_int = sync_int;
    assign unused_ok  = ^{status_in[WIDTH-1:16], status_in[7:2], cause_in[WIDTH-1:16],
                          cause_in[7:0], cmp_we, cmp_wdata};
`endif

    assign int_pending = status_in[0] && !status_in[1] &&
                         (|((cause_in[15:8] | {cp0_hw_int, 2'b00}) & status_in[15:8]));

    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        take          = 1'b0;
        take_eret     = 1'b0;
        take_addr     = 1'b0;
        bad_from_pc   = 1'b0;
        bad_from_data = 1'b0;
        take_code     = EXC_INT;
        if (state_q == ST_IDLE && m_valid) begin
            take = 1'b1;
            if (int_pending) begin
                take_code = EXC_INT;
            end else if (m_exc[EXC_BIT_ADEL_IF]) begin
                take_code   = EXC_ADEL;
                take_addr   = 1'b1;
                bad_from_pc = 1'b1;
            end else if (m_exc[EXC_BIT_RI]) begin
                take_code = EXC_RI;
            end else if (m_exc[EXC_BIT_OV]) begin
                take_code = EXC_OV;
            end else if (m_exc[EXC_BIT_SYS]) begin
                take_code = EXC_SYS;
            end else if (m_exc[EXC_BIT_BP]) begin
                take_code = EXC_BP;
            end else if (m_exc[EXC_BIT_ADEL_D]) begin
                take_code     = EXC_ADEL;
                take_addr     = 1'b1;
                bad_from_data = 1'b1;
            end else if (m_exc[EXC_BIT_ADES]) begin
                take_code     = EXC_ADES;
                take_addr     = 1'b1;
                bad_from_data = 1'b1;
            end else if (m_eret) begin
                take_eret = 1'b1;
            end else begin
                take = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (take) state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Event capture; an ERET leaves the exception record untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q        <= '0;
            badaddr_q    <= '0;
            redir_pc_q   <= '0;
            exccode_q    <= '0;
            bd_q         <= 1'b0;
            eret_q       <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            if (take) begin
                eret_q <= take_eret;
                if (!take_eret) begin
                    epc_q        <= m_bd ? m_pc - WIDTH'(4) : m_pc;
                    bd_q         <= m_bd;
                    exccode_q    <= take_code;
                    addr_fault_q <= take_addr;
                    if (bad_from_pc)   badaddr_q <= m_pc;
                    if (bad_from_data) badaddr_q <= m_badvaddr;
                end
            end
            if (state_q == ST_COMMIT) begin
                redir_pc_q <= eret_q ? epc_in : EXC_VECTOR;
            end
        end
    end

    always_comb begin
        cp0_we         = '0;
        cp0_exl        = 1'b0;
        flush          = 1'b0;
        busy           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            ST_COMMIT: begin
                flush                 = 1'b1;
                busy                  = 1'b1;
                cp0_we[CP0_WE_STATUS] = 1'b1;
                if (!eret_q) begin
                    cp0_exl                 = 1'b1;
                    cp0_we[CP0_WE_CAUSE]    = 1'b1;
                    cp0_we[CP0_WE_EPC]      = 1'b1;
                    cp0_we[CP0_WE_BADVADDR] = addr_fault_q;
                end
            end
            ST_REDIRECT: begin
                flush          = 1'b1;
                busy           = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = redir_pc_q;
            end
            default: ;
        endcase
    end

    assign cp0_epc     = epc_q;
    assign cp0_badaddr = badaddr_q;
    assign cp0_exccode = exccode_q;
    assign cp0_bd      = bd_q;

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, 32, data/address width.
REQ-002 SHALL have parameter EXC_VECTOR, 32'hBFC00380, exception entry PC.
REQ-003 SHALL have ports: clk  in  1  single clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: m_valid  in  1  commit-stage instruction valid; m_pc  in  WIDTH  its PC; m_bd  in  1  in delay slot; m_eret  in  1  ERET.
REQ-005 SHALL have ports: m_exc  in  7  flags {AdES,AdEL-data,Bp,Sys,Ov,RI,AdEL-fetch} (bit6..0); m_badvaddr  in  WIDTH  data fault address.
REQ-006 SHALL have ports: hw_int  in  6  raw asynchronous interrupts; status_in, cause_in, epc_in  in  WIDTH  current CP0 Status/Cause/EPC.
REQ-007 SHALL have ports: cmp_we  in  1  compare write; cmp_wdata  in  WIDTH  compare value.
REQ-008 SHALL have ports: cp0_we  out  WIDTH  per-register write strobes; cp0_epc, cp0_badaddr  out  WIDTH; cp0_exccode  out  5; cp0_exl, cp0_bd  out  1; cp0_hw_int  out  6  synchronized interrupts.
REQ-009 SHALL have ports: flush  out  1  pipeline kill; redirect_valid  out  1; redirect_pc  out  WIDTH; redirect_ready  in  1  fetch accepts redirect; busy  out  1  FSM not IDLE.

Function
REQ-010 SHALL synchronize hw_int through two flops into cp0_hw_int (2-cycle latency).
REQ-011 SHALL flag interrupt pending when status_in[0]=1, status_in[1]=0, and ((cause_in[15:8] | {cp0_hw_int,2'b0}) & status_in[15:8]) != 0.
REQ-012 SHALL, in IDLE with m_valid=1, take an event with priority: interrupt > AdEL-fetch > RI > Ov > Sys > Bp > AdEL-data > AdES > ERET; m_valid=0 takes nothing.
REQ-013 SHALL map exccode: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
REQ-014 SHALL register in the take cycle T: epc=m_bd?m_pc-4:m_pc, bd=m_bd, exccode, badaddr (m_pc for AdEL-fetch, m_badvaddr for data faults, else unchanged).
REQ-015 SHALL use FSM IDLE->COMMIT (always 1 cycle)->REDIRECT->IDLE; REDIRECT holds until redirect_valid&&redirect_ready.
REQ-016 SHALL in COMMIT for exceptions pulse cp0_we bits 12,13,14 (plus bit 8 for address faults) with cp0_exl=1; for ERET pulse bit 12 only with cp0_exl=0; cp0_we=0 in every other cycle.
REQ-017 SHALL drive redirect_pc=EXC_VECTOR for exceptions, epc_in sampled in COMMIT for ERET; redirect_pc stable while redirect_valid=1.
REQ-018 SHALL assert flush in COMMIT and REDIRECT; busy=1 outside IDLE.
REQ-019 SHALL ignore m_valid/m_exc/m_eret while busy (instruction being flushed).
REQ-020 SHALL return to IDLE the cycle after handshake; a new take is allowed that same IDLE cycle.

Reset
REQ-021 SHALL on rst asynchronously force IDLE, clear synchronizers and captures, drive all outputs 0, including mid-COMMIT or mid-REDIRECT.

Configuration
REQ-022 SHALL, with EXC_TIMER_INT_EN defined, include 32-bit count (+1 every cycle, wraps) and compare (reset 0, written by cmp_we); count==compare sets timer-pending, cleared by cmp_we; timer-pending replaces synchronized hw_int[5] on cp0_hw_int[5].
REQ-023 SHALL, without EXC_TIMER_INT_EN, omit timer logic, ignore cmp_we/cmp_wdata, pass synchronized hw_int[5] through.

Structure
REQ-024 SHALL place exccode constants, m_exc bit indices, FSM state enum and default EXC_VECTOR in shared package cpu_exc_pkg.
REQ-025 SHALL instantiate one sub-module int_sync (6-bit two-flop synchronizer).

Verification
REQ-026 SHALL test: m_valid=1, m_exc=7'b0001000 (Sys), m_pc=0x80001000, m_bd=0 -> next cycle cp0_we=0x7000, exccode=8, epc=0x80001000, exl=1; then redirect_pc=0xBFC00380 until ready.
REQ-027 SHALL test: m_exc=7'b0000011 (RI+AdEL-fetch), m_bd=1, m_pc=0x80000104 -> exccode=4, cp0_we=0x7100, badaddr=0x80000104, epc=0x80000100, bd=1.
REQ-028 SHALL test: status_in=0x00000401, hw_int=6'b000001 held, m_valid=1 with Ov -> exccode 0 (interrupt wins) after 2-cycle sync.
REQ-029 SHALL test: m_eret=1, epc_in=0x80002000, redirect_ready low 3 cycles -> cp0_we=0x1000, exl=0, redirect_valid held 3 cycles then IDLE.
REQ-030 SHALL test: rst asserted during REDIRECT -> flush, redirect_valid, busy drop to 0 immediately.
REQ-031 SHALL test (EXC_TIMER_INT_EN): cmp_wdata=10 -> cp0_hw_int[5]=1 when count=10, cleared after cmp_we.
